// File: rtl/fpn_pkg.sv
// Shared types and defaults for the FPN border-pixel frame sequencer.
// Latency: none (types and constants only).
// Backpressure: n/a.
package fpn_pkg;
  localparam int NPIX_DEF = 24;
  localparam int AW_DEF   = 5;
  localparam int CW_DEF   = 6;
  localparam int STAR_XW  = 10;
  localparam int STAR_YW  = 10;
  localparam int STAR_W   = STAR_XW + STAR_YW;

  typedef struct packed {
    logic [STAR_XW-1:0] x;
    logic [STAR_YW-1:0] y;
  } star_t;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, WAIT_DIV, READY} state_t;
endpackage

// File: rtl/fpn_sched_star_track.sv
// Frame sync edge detect, star-move detect and saturating frame/still counters.
// Latency: rise/change pulses are combinational; counters update on the next edge.
// Backpressure: none; everything holds while enable is low.
module star_track
  import fpn_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          vs_in,
  input  star_t         star,
  output logic          rise,
  output logic          change,
  output logic          pp_sel,
  output logic [CW-1:0] frames,
  output logic [CW-1:0] still_cnt,
  output logic [CW-1:0] still_lat
);
  localparam logic [CW-1:0] CMAX = '1;

  logic  vs_d;
  star_t star_q;

  assign rise   = enable & vs_in & ~vs_d;
  assign change = enable & (star != star_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d      <= 1'b0;
      star_q    <= '0;
      pp_sel    <= 1'b0;
      frames    <= '0;
      still_cnt <= '0;
      still_lat <= '0;
    end else if (enable) begin
      vs_d   <= vs_in;
      star_q <= star;
      if (rise) begin
        pp_sel <= ~pp_sel;
        if (frames != CMAX) frames <= frames + 1'b1;
      end
      // a move on the same cycle as a frame edge restarts the still count
      if (change) begin
        still_lat <= still_cnt;
        still_cnt <= '0;
      end else if (rise && still_cnt != CMAX) begin
        still_cnt <= still_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpn_sched.sv
// Frame sequencer: drains border accumulators through the divider pair, collects quotients, hands results to host.
// Latency: drain starts the cycle after a star move; div_in_valid trails drain_en by 1 cycle. Macro FPN_SCHED_TIMEOUT_EN adds a divider watchdog.
// Backpressure: host paces readout with out_en; a pending move waits for readout to finish.
module fpn_sched
  import fpn_pkg::*;
#(
  parameter int NPIX = NPIX_DEF,
  parameter int AW   = AW_DEF,
  parameter int CW   = CW_DEF
`ifdef FPN_SCHED_TIMEOUT_EN
  ,
  parameter int TMO  = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vs_in,
  input  logic [STAR_W-1:0] star,
  output logic              pp_sel,
  output logic [CW-1:0]     still_cnt,
  output logic              acc_clear,
  output logic [AW-1:0]     drain_addr,
  output logic              drain_en,
  output logic              div_in_valid,
  output logic [CW-1:0]     div_divisor,
  input  logic              div_out_valid,
  output logic              res_wr_en,
  output logic [AW-1:0]     res_wr_addr,
  output logic              res_ready,
  input  logic              out_en,
  output logic [AW-1:0]     res_rd_addr,
  output logic              overrun
);
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  logic          rise, change, start_ok;
  logic [CW-1:0] frames, still_lat;

  state_t        state, state_nx;
  logic [AW-1:0] drain_q, drain_nx, wr_q, wr_nx, rd_q, rd_nx;
  logic          pend_q, pend_nx, ovr_q, ovr_nx, div_vld_q;
  logic          drain_act, wr_act, timeout;

`ifdef FPN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] wd_q, wd_nx;
`endif

  star_track #(.CW(CW)) u_track (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .vs_in    (vs_in),
    .star     (star_t'(star)),
    .rise     (rise),
    .change   (change),
    .pp_sel   (pp_sel),
    .frames   (frames),
    .still_cnt(still_cnt),
    .still_lat(still_lat)
  );

  always_comb begin
    state_nx  = state;
    drain_nx  = drain_q;
    wr_nx     = wr_q;
    rd_nx     = rd_q;
    pend_nx   = pend_q;
    ovr_nx    = ovr_q;
    drain_act = 1'b0;
    wr_act    = 1'b0;
    timeout   = 1'b0;
    start_ok  = change && (frames != '0);
`ifdef FPN_SCHED_TIMEOUT_EN
    wd_nx     = '0;
`endif
    case (state)
      IDLE: if (rise) state_nx = ACCUM;
      ACCUM: if (start_ok) state_nx = DRAIN;
      DRAIN: begin
        drain_act = 1'b1;
        drain_nx  = drain_q + 1'b1;
        if (drain_q == LAST) begin
          drain_nx = '0;
          state_nx = WAIT_DIV;
        end
        // short divider latency returns quotients while still issuing
        if (div_out_valid) begin
          wr_act = 1'b1;
          wr_nx  = wr_q + 1'b1;
        end
      end
      WAIT_DIV: begin
        if (div_out_valid) begin
          wr_act = 1'b1;
          wr_nx  = wr_q + 1'b1;
          if (wr_q == LAST) begin
            wr_nx    = '0;
            state_nx = READY;
          end
        end
`ifdef FPN_SCHED_TIMEOUT_EN
        wd_nx   = div_out_valid ? '0 : wd_q + 1'b1;
        timeout = !div_out_valid && (wd_q == TW'(TMO - 1));
`endif
      end
      READY: begin
        if (start_ok) pend_nx = 1'b1;
        if (out_en) begin
          rd_nx = rd_q + 1'b1;
          if (rd_q == LAST) begin
            rd_nx    = '0;
            pend_nx  = 1'b0;
            state_nx = (pend_q || start_ok) ? DRAIN : ACCUM;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // a new frame (or a dead divider) mid-drain invalidates the partial set
    if ((state == DRAIN || state == WAIT_DIV) && (rise || timeout)) begin
      ovr_nx    = 1'b1;
      state_nx  = ACCUM;
      drain_nx  = '0;
      wr_nx     = '0;
      drain_act = 1'b0;
      wr_act    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
      div_vld_q <= 1'b0;
`ifdef FPN_SCHED_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else if (enable) begin
      state     <= state_nx;
      drain_q   <= drain_nx;
      wr_q      <= wr_nx;
      rd_q      <= rd_nx;
      pend_q    <= pend_nx;
      ovr_q     <= ovr_nx;
      div_vld_q <= drain_act;
`ifdef FPN_SCHED_TIMEOUT_EN
      wd_q      <= wd_nx;
`endif
    end
  end

  assign acc_clear    = (still_cnt == '0);
  assign drain_addr   = drain_q;
  assign drain_en     = drain_act & enable;
  assign div_in_valid = div_vld_q & enable;
  assign div_divisor  = (still_lat == '0) ? CW'(1) : still_lat;
  assign res_wr_en    = wr_act & enable;
  assign res_wr_addr  = wr_q;
  assign res_ready    = (state == READY);
  assign res_rd_addr  = rd_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_fpn_sched.sv
// Scoreboarded random bench for fpn_sched with a transaction-level frame/star model and a delay-line divider.
`timescale 1ns/1ps
module tb_fpn_sched;
  localparam int NPIX = 24;
  localparam int CMAX = 63;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst_n, enable, vs_in, div_out_valid, out_en;
  logic [19:0] star;
  logic        pp_sel, acc_clear, drain_en, div_in_valid, res_wr_en, res_ready, overrun;
  logic [5:0]  still_cnt, div_divisor;
  logic [4:0]  drain_addr, res_wr_addr, res_rd_addr;

  fpn_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vs_in(vs_in), .star(star),
    .pp_sel(pp_sel), .still_cnt(still_cnt), .acc_clear(acc_clear),
    .drain_addr(drain_addr), .drain_en(drain_en), .div_in_valid(div_in_valid),
    .div_divisor(div_divisor), .div_out_valid(div_out_valid),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_ready(res_ready),
    .out_en(out_en), .res_rd_addr(res_rd_addr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int addr; int div; } drain_e_t;
  drain_e_t exp_drain[$];
  int       exp_wr[$];
  int       exp_rd[$];

  // divider: fixed delay line, stalls with enable, can be muted after a quota
  logic [15:0] pipe = '0;
  int div_lat   = 5;
  int div_sent  = 0;
  int div_limit = 1 << 30;
  assign div_out_valid = pipe[div_lat-1] && (div_sent < div_limit);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else if (enable) begin
      pipe <= {pipe[14:0], div_in_valid};
      if (div_out_valid) div_sent <= div_sent + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  logic last_drain = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) last_drain <= 1'b0;
    else begin
      if (enable) begin
        chk("div_in_valid_delay", div_in_valid, last_drain);
        last_drain <= drain_en;
      end
      if (drain_en) begin
        chk("drain_expected", int'(exp_drain.size() != 0), 1);
        if (exp_drain.size() != 0) begin
          drain_e_t e;
          e = exp_drain.pop_front();
          chk("drain_addr", drain_addr, e.addr);
          chk("div_divisor", div_divisor, e.div);
        end
      end
      if (res_wr_en) begin
        chk("wr_expected", int'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) chk("res_wr_addr", res_wr_addr, exp_wr.pop_front());
      end
      if (out_en && res_ready && enable) begin
        chk("rd_expected", int'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) chk("res_rd_addr", res_rd_addr, exp_rd.pop_front());
      end
    end
  end

  // model: phase 0 idle, 1 accumulating, 2 draining/waiting, 3 results ready
  int m_pp, m_frames, m_still, m_lat, m_phase, m_pend, m_ovr;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pp = 0; m_frames = 0; m_still = 0; m_lat = 0; m_phase = 0; m_pend = 0; m_ovr = 0;
  endtask

  task automatic model_rise();
    m_pp = m_pp ^ 1;
    if (m_frames < CMAX) m_frames++;
    if (m_still < CMAX) m_still++;
    if (m_phase == 0) m_phase = 1;
    else if (m_phase == 2) begin m_ovr = 1; m_phase = 1; end
  endtask

  task automatic push_drain(input int ndrain, input int nwr);
    int d;
    d = (m_lat == 0) ? 1 : m_lat;
    for (int a = 0; a < ndrain; a++) begin
      drain_e_t e;
      e.addr = a; e.div = d;
      exp_drain.push_back(e);
    end
    for (int a = 0; a < nwr; a++) exp_wr.push_back(a);
  endtask

  task automatic vs_frame(input int gap);
    vs_in = 1'b1;
    model_rise();
    tick(1);
    vs_in = 1'b0;
    tick(gap);
  endtask

  task automatic star_change(input bit with_vs, input int ndrain, input int nwr);
    int prev, ph0, fr0;
    logic [19:0] s;
    prev = m_still; ph0 = m_phase; fr0 = m_frames;
    do s = 20'($urandom); while (s == star);
    star = s;
    if (with_vs) begin vs_in = 1'b1; model_rise(); end
    m_lat = prev;
    m_still = 0;
    if (ph0 == 1 && fr0 != 0) begin push_drain(ndrain, nwr); m_phase = 2; end
    else if (ph0 == 3 && fr0 != 0) begin push_drain(NPIX, NPIX); m_pend = 1; end
    tick(1);
    vs_in = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_pp_sel"}, pp_sel, m_pp);
    chk({tag, "_still_cnt"}, still_cnt, m_still);
    chk({tag, "_acc_clear"}, acc_clear, int'(m_still == 0));
    chk({tag, "_overrun"}, overrun, m_ovr);
  endtask

  task automatic wait_ready(input bit jitter);
    int n = 0;
    while (!res_ready && n < 2000) begin
      if (jitter) enable = ($urandom_range(0, 3) != 0);
      tick(1);
      n++;
    end
    enable = 1'b1;
    chk("ready_seen", res_ready, 1);
    chk("drain_queue_empty", exp_drain.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    m_phase = 3;
  endtask

  task automatic readout(input bit hold);
    int reads = 0;
    int n = 0;
    for (int a = 0; a < NPIX; a++) exp_rd.push_back(a);
    while (reads < NPIX && n < 2000) begin
      out_en = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
      enable = hold ? 1'b1 : ($urandom_range(0, 4) != 0);
      if (out_en && res_ready && enable) reads++;
      tick(1);
      n++;
    end
    out_en = 1'b0;
    enable = 1'b1;
    chk("reads_done", reads, NPIX);
    chk("ready_after_read", res_ready, 0);
    chk("rd_addr_after_read", res_rd_addr, 0);
    if (m_pend != 0) begin m_phase = 2; m_pend = 0; end
    else m_phase = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pp_sel"}, pp_sel, 0);
    chk({tag, "_still_cnt"}, still_cnt, 0);
    chk({tag, "_acc_clear"}, acc_clear, 1);
    chk({tag, "_drain_en"}, drain_en, 0);
    chk({tag, "_drain_addr"}, drain_addr, 0);
    chk({tag, "_div_in_valid"}, div_in_valid, 0);
    chk({tag, "_div_divisor"}, div_divisor, 1);
    chk({tag, "_res_wr_en"}, res_wr_en, 0);
    chk({tag, "_res_wr_addr"}, res_wr_addr, 0);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_res_rd_addr"}, res_rd_addr, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; vs_in = 1'b0; star = '0; out_en = 1'b0;
    model_reset();
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // three still frames, no drain
    repeat (3) vs_frame(2);
    check_status("three_frames");

    // four still frames then a move; a second move while results wait
    vs_frame(2);
    star_change(1'b0, NPIX, NPIX);
    check_status("first_move");
    wait_ready(1'b0);
    star_change(1'b0, NPIX, NPIX);
    check_status("move_in_ready");
    readout(1'b1);
    wait_ready(1'b0);
    readout(1'b0);
    out_en = 1'b1;
    tick(3);
    out_en = 1'b0;
    chk("stray_out_en_rd_addr", res_rd_addr, 0);
    chk("stray_out_en_ready", res_ready, 0);

    // random frame counts, latencies, a saturating run and a coincident move+frame
    for (int it = 0; it < 4; it++) begin
      int nfr;
      nfr = (it == 1) ? 70 : $urandom_range(1, 5);
      repeat (nfr) vs_frame($urandom_range(1, 3));
      check_status("loop_frames");
      div_lat = $urandom_range(1, 10);
      star_change(it == 2, NPIX, NPIX);
      check_status("loop_move");
      wait_ready(it != 0);
      readout(it == 3);
    end
    div_lat = 5;

`ifdef FPN_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      vs_frame(2);
      div_limit = div_sent + 12;
      star_change(1'b0, NPIX, 12);
      tick(NPIX);
      while (!overrun && n < 400) begin tick(1); n++; end
      chk("timeout_cycles", n, TMO);
      m_ovr = 1; m_phase = 1;
      check_status("after_timeout");
      chk("timeout_no_ready", res_ready, 0);
      chk("timeout_wr_queue", exp_wr.size(), 0);
      div_limit = 1 << 30;
    end
`endif

    // reset pulse while stuck waiting on the divider
    vs_frame(2);
    div_limit = div_sent + 12;
    star_change(1'b0, NPIX, 12);
    tick(NPIX + 10);
    chk("stuck_wr_addr", res_wr_addr, 12);
    chk("stuck_no_ready", res_ready, 0);
    rst_n = 1'b0;
    vs_in = 1'b0;
    star = '0;
    #2;
    check_reset_outputs("mid_reset");
    chk("mid_reset_drain_queue", exp_drain.size(), 0);
    chk("mid_reset_wr_queue", exp_wr.size(), 0);
    model_reset();
    div_limit = 1 << 30;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // frame edge at drain address 10 aborts the set
    vs_frame(2);
    vs_frame(2);
    div_lat = 12;
    star_change(1'b0, 10, 0);
    tick(10);
    vs_in = 1'b1;
    model_rise();
    tick(1);
    vs_in = 1'b0;
    tick(30);
    check_status("after_abort");
    chk("abort_no_ready", res_ready, 0);
    chk("abort_drain_queue", exp_drain.size(), 0);
    div_lat = 5;
    star_change(1'b0, NPIX, NPIX);
    wait_ready(1'b0);
    readout(1'b0);
    check_status("after_recovery");

    tick(5);
    chk("final_drain_queue", exp_drain.size(), 0);
    chk("final_wr_queue", exp_wr.size(), 0);
    chk("final_rd_queue", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
